// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//   Load-use hazard and halt controller sitting between the ID and EX stages.
//   A load in EX whose destination matches a source of the instruction in ID
//   freezes PC and IF/ID and pushes bubbles into EX for STALL_CYCLES cycles.
//   A HALT opcode in ID latches a sticky halt that only reset clears.
//   Detected load-use hazards are tallied in a saturating counter.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous, active-high reset
//   id_valid       in   instruction_ID holds a real instruction
//   ex_valid       in   instruction_EX holds a real (non-bubble) instruction
//   instruction_ID in   [IW-1:0] instruction in ID
//   instruction_EX in   [IW-1:0] instruction in EX
//   halt           out  sticky processor halt
//   pc_enable      out  PC update enable
//   if_id_enable   out  IF/ID pipeline-register enable
//   bubble_ex      out  force NOP into ID/EX this cycle
//   stall_active   out  high while a stall cycle is in progress
//   hazard_count   out  [CW-1:0] saturating count of load-use hazards
//   state_dbg      out  [1:0] current FSM state (0=RUN, 1=STALL, 2=HALTED)
//
// Handshake: there is no valid/ready pair here; id_valid/ex_valid are
// qualifiers only. When a valid is low the matching instruction bus is
// don't-care and is masked before any decode reaches an output.
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int          IW           = 16,
  parameter int          RW           = 4,
  parameter logic [3:0]  OP_LOAD      = 4'hB,
  parameter logic [3:0]  OP_HALT      = 4'hF,
  parameter int          STALL_CYCLES = 1,
  parameter bit          IGNORE_R0    = 1'b1,
  parameter int          CW           = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic          ex_valid,
  input  logic [IW-1:0] instruction_ID,
  input  logic [IW-1:0] instruction_EX,
  output logic          halt,
  output logic          pc_enable,
  output logic          if_id_enable,
  output logic          bubble_ex,
  output logic          stall_active,
  output logic [CW-1:0] hazard_count,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [CW-1:0] hazard_count_q;
  logic          count_inc;

  // Field decode
  logic [3:0]    id_op, ex_op;
  logic [RW-1:0] id_rs1, id_rs2, ex_rd;
  logic          unused_bits;

  assign id_op  = instruction_ID[IW-1 -: 4];
  assign id_rs1 = instruction_ID[IW-5 -: RW];
  assign id_rs2 = instruction_ID[IW-5-RW -: RW];
  assign ex_op  = instruction_EX[IW-1 -: 4];
  assign ex_rd  = instruction_EX[IW-5 -: RW];

  assign unused_bits = ^{instruction_ID[IW-5-2*RW:0], instruction_EX[IW-5-RW:0]};

  // The valid qualifiers are the leftmost AND operands so that a low valid
  // forces a clean 0 even when the instruction bus is X.
  logic id_is_halt;
  logic hit;

  assign id_is_halt = id_valid & (id_op == OP_HALT);
  assign hit = ex_valid & id_valid & (ex_op == OP_LOAD)
             & ((ex_rd == id_rs1) | (ex_rd == id_rs2))
             & ~(IGNORE_R0 & (ex_rd == '0));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    count_inc    = 1'b0;
    halt         = 1'b0;
    pc_enable    = 1'b1;
    if_id_enable = 1'b1;
    bubble_ex    = 1'b0;
    stall_active = 1'b0;

    case (state_q)
      RUN: begin
        if (id_is_halt) begin
          // Halt wins over a simultaneous hit and is not counted as a hazard.
          pc_enable    = 1'b0;
          if_id_enable = 1'b0;
          state_d      = HALTED;
        end else if (hit) begin
          // The hit cycle itself is the first bubble.
          pc_enable    = 1'b0;
          if_id_enable = 1'b0;
          bubble_ex    = 1'b1;
          stall_active = 1'b1;
          count_inc    = 1'b1;
          if (STALL_CYCLES > 1) begin
            state_d = STALL;
            cnt_d   = 4'(STALL_CYCLES - 1);
          end
        end
      end
      STALL: begin
        pc_enable    = 1'b0;
        if_id_enable = 1'b0;
        bubble_ex    = 1'b1;
        stall_active = 1'b1;
        if (cnt_q <= 4'd1) begin
          state_d = RUN;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HALTED: begin
        halt         = 1'b1;
        pc_enable    = 1'b0;
        if_id_enable = 1'b0;
        bubble_ex    = 1'b1;
      end
      default: begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    endcase

    // While reset is held the pipeline is released, independent of decode.
    if (rst) begin
      halt         = 1'b0;
      pc_enable    = 1'b1;
      if_id_enable = 1'b1;
      bubble_ex    = 1'b0;
      stall_active = 1'b0;
      count_inc    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      cnt_q          <= 4'd0;
      hazard_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (count_inc && (hazard_count_q != {CW{1'b1}})) begin
        hazard_count_q <= hazard_count_q + CW'(1);
      end
    end
  end

  assign hazard_count = hazard_count_q;
  assign state_dbg    = state_q;

endmodule
